// File: rtl/lsu_mem_port.sv
// Memory-stage load/store unit: validates an EX access, runs the request/grant/response
// bus handshake, and returns aligned, extended load data or a completion/fault to writeback.
module lsu_mem_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    state;
    logic [CW-1:0] timer;
    logic          is_load;
    logic [2:0]    funct3_q;
    logic [1:0]    offset_q;
    logic [4:0]    rd_q;

    logic          accept;
    logic          has_op;
    logic          code_ok;
    logic          misaligned;
    logic          req_fault;
    logic [3:0]    store_be;
    logic [31:0]   store_wdata;
    logic [31:0]   shifted;
    logic [31:0]   load_value;
    logic          timer_done;

    assign ex_ready   = (state == S_IDLE);
    assign accept     = ex_valid && ex_ready;
    assign has_op     = ex_load || ex_store;
    assign timer_done = (timer == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        code_ok = 1'b0;
        if (ex_load && !ex_store) begin
            code_ok = (ex_funct3 != 3'b011) && (ex_funct3 != 3'b110) && (ex_funct3 != 3'b111);
        end else if (ex_store && !ex_load) begin
            code_ok = (ex_funct3 <= 3'b010);
        end
        misaligned = 1'b0;
        if (ex_funct3[1:0] == 2'b01) begin
            misaligned = ex_addr[0];
        end else if (ex_funct3[1:0] == 2'b10) begin
            misaligned = (ex_addr[1:0] != 2'b00);
        end
        req_fault = !code_ok || misaligned;
    end

    // Store lanes: narrow data is replicated so every enabled byte lane sees the right byte.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << ex_addr[1:0];
                store_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                store_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = ex_wdata;
            end
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_value = {24'h0, shifted[7:0]};
            3'b101:  load_value = {16'h0, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            is_load   <= 1'b0;
            funct3_q  <= 3'b000;
            offset_q  <= 2'b00;
            rd_q      <= 5'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_fault  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'h0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_fault <= 1'b0;
            timer    <= timer + CW'(1);
            case (state)
                S_IDLE: begin
                    if (accept && has_op) begin
                        if (req_fault) begin
                            wb_valid <= 1'b1;
                            wb_fault <= 1'b1;
                        end else begin
                            state     <= S_REQ;
                            timer     <= '0;
                            is_load   <= ex_load;
                            funct3_q  <= ex_funct3;
                            offset_q  <= ex_addr[1:0];
                            rd_q      <= ex_rd;
                            mem_req   <= 1'b1;
                            mem_we    <= ex_store;
                            mem_addr  <= {ex_addr[31:2], 2'b00};
                            mem_be    <= ex_store ? store_be : 4'b1111;
                            mem_wdata <= ex_store ? store_wdata : 32'h0;
                        end
                    end
                end
                S_REQ: begin
                    // A real bus event in the final counted cycle still wins over the timeout.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (!is_load) begin
                            state    <= S_IDLE;
                            wb_valid <= 1'b1;
                        end else if (mem_rvalid) begin
                            state    <= S_IDLE;
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= load_value;
                        end else begin
                            state <= S_RESP;
                        end
                    end else if (timer_done) begin
                        state    <= S_IDLE;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_fault <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        state    <= S_IDLE;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= load_value;
                    end else if (timer_done) begin
                        state    <= S_IDLE;
                        wb_valid <= 1'b1;
                        wb_fault <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port: a byte-level reference model predicts bus lanes,
// load results, faults and timeouts for each transaction.
module tb_lsu_mem_port;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_fault;

    int checks = 0;
    int errors = 0;

    lsu_mem_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int accessSize(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit isLegal(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr);
        int size;
        if (ld && st) return 0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (st && f3 > 3'd2) return 0;
        size = accessSize(f3);
        return (int'(addr[1:0]) % size) == 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        int size;
        if (!st) return 4'b1111;
        be = 4'b0000;
        size = accessSize(f3);
        for (int i = 0; i < size; i++) be[(int'(off) + i) % 4] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] w;
        int size;
        size = accessSize(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % size) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
        logic [31:0] v;
        int size;
        size = accessSize(f3);
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*((int'(off) + i) % 4) +: 8];
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        return v;
    endfunction

    // One complete access: offer it, play the bus side with the given delays, check writeback.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input int gntDly, input int rvDly,
                                 input logic [31:0] rdata);
        int gIdx;
        int rIdx;
        int lastIdx;
        bit timedOut;
        checkOutput("ready_before_accept", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        if (!ld && !st) begin
            checkOutput("ignored_wb_valid", 32'(wb_valid), 32'd0);
            checkOutput("ignored_mem_req", 32'(mem_req), 32'd0);
            return;
        end
        if (!isLegal(ld, st, f3, addr)) begin
            checkOutput("fault_wb_valid", 32'(wb_valid), 32'd1);
            checkOutput("fault_wb_fault", 32'(wb_fault), 32'd1);
            checkOutput("fault_wb_we", 32'(wb_we), 32'd0);
            checkOutput("fault_mem_req", 32'(mem_req), 32'd0);
            checkOutput("fault_ready", 32'(ex_ready), 32'd1);
            return;
        end
        checkOutput("pulse_over", 32'(wb_valid), 32'd0);
        gIdx = gntDly;
        rIdx = ld ? gntDly + rvDly : gntDly;
        timedOut = (rIdx >= TO);
        lastIdx = timedOut ? TO - 1 : rIdx;
        for (int c = 0; c <= lastIdx; c++) begin
            checkOutput("busy_ready", 32'(ex_ready), 32'd0);
            if (c <= gIdx) begin
                checkOutput("req_high", 32'(mem_req), 32'd1);
                checkOutput("req_we", 32'(mem_we), 32'(st));
                checkOutput("req_addr", mem_addr, {addr[31:2], 2'b00});
                checkOutput("req_be", 32'(mem_be), 32'(modelBe(st, f3, addr[1:0])));
                if (st) checkOutput("req_wdata", mem_wdata, modelWdata(f3, wdata));
            end else begin
                checkOutput("resp_req_low", 32'(mem_req), 32'd0);
            end
            mem_gnt = (c == gIdx);
            mem_rvalid = ld && (c == rIdx);
            mem_rdata = (c == rIdx) ? rdata : $urandom;
            @(posedge clk); @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end
        checkOutput("done_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("done_wb_fault", 32'(wb_fault), 32'(timedOut));
        checkOutput("done_wb_we", 32'(wb_we), 32'(ld && !timedOut));
        checkOutput("done_mem_req", 32'(mem_req), 32'd0);
        checkOutput("done_ready", 32'(ex_ready), 32'd1);
        if (ld && !timedOut) begin
            checkOutput("done_wb_rd", 32'(wb_rd), 32'(rd));
            checkOutput("done_wb_data", wb_data, modelLoad(f3, addr[1:0], rdata));
        end
    endtask

    initial begin
        int op;
        logic [2:0]  f3;
        logic [31:0] addr;
        rst_n = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
        ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_ready", 32'(ex_ready), 32'd1);

        applyStimulus(1, 0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 0, 0, 32'h80FF_FF00);
        checkOutput("lb_const", wb_data, 32'hFFFF_FF80);
        applyStimulus(1, 0, 3'b101, 32'h0000_2002, 32'h0, 5'd9, 3, 2, 32'hBEEF_1234);
        checkOutput("lhu_const", wb_data, 32'h0000_BEEF);
        applyStimulus(0, 1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 5'd0, 1, 0, 32'h0);
        applyStimulus(1, 0, 3'b010, 32'h0000_4001, 32'h0, 5'd3, 0, 0, 32'h0);
        applyStimulus(1, 1, 3'b010, 32'h0000_4000, 32'h0, 5'd3, 0, 0, 32'h0);
        applyStimulus(1, 0, 3'b011, 32'h0000_4000, 32'h0, 5'd3, 0, 0, 32'h0);
        applyStimulus(0, 1, 3'b011, 32'h0000_4000, 32'h0, 5'd3, 0, 0, 32'h0);
        applyStimulus(0, 0, 3'b010, 32'h0000_4000, 32'h0, 5'd3, 0, 0, 32'h0);

        applyStimulus(1, 0, 3'b010, 32'h0000_5000, 32'h0, 5'd7, 0, 100, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("late_rvalid_ignored", 32'(wb_valid), 32'd0);
        checkOutput("late_rvalid_ready", 32'(ex_ready), 32'd1);
        applyStimulus(1, 0, 3'b010, 32'h0000_5004, 32'h0, 5'd8, 1, 1, 32'hCAFE_F00D);

        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_6000; ex_rd = 5'd4;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; ex_load = 1'b0;
        checkOutput("pre_reset_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_reset_req", 32'(mem_req), 32'd0);
        checkOutput("mid_reset_ready", 32'(ex_ready), 32'd1);
        checkOutput("mid_reset_wb_data", wb_data, 32'd0);
        checkOutput("mid_reset_wb_rd", 32'(wb_rd), 32'd0);
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checkOutput("post_reset_no_wb", 32'(wb_valid), 32'd0);

        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            applyStimulus(op >= 2 && op <= 5 || op == 1, op >= 6 || op == 1, f3, addr, $urandom,
                          5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom_range(0, 4),
                          $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-stage load/store unit.
- Consumes the load/store intent, funct3 width code and effective address produced by the decode/execute path.
- Drives the data-memory bus with a request/grant/response handshake; returns aligned, extended load data or a store completion to writeback.
- Stalls the pipeline via ex_ready while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ+RESP before the access is abandoned with a fault.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  access request from EX
- ex_ready  out  1  unit can accept (high only in IDLE)
- ex_load  in  1  request is a load
- ex_store  in  1  request is a store
- ex_funct3  in  3  RV32I width/sign code
- ex_addr  in  32  effective byte address
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  load destination register
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits[1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  bus accepted request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle completion pulse
- wb_we  out  1  register write required (loads only)
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- wb_fault  out  1  misaligned, illegal or timed-out access

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low: rst_n sampled low at a clk edge resets the unit.
- Reset values:
  - state = IDLE.
  - mem_req = mem_we = 0; mem_be = 0; mem_addr = mem_wdata = 0.
  - wb_valid = wb_we = wb_fault = 0; wb_rd = 0; wb_data = 0.
  - Timeout counter = 0.
  - Reset mid-access drops the access silently; no wb_valid.
- States: IDLE, REQ, RESP.
- Accept: ex_valid && ex_ready at edge T latches the address, funct3, rd and data.
- Checks on accept:
  - Both ex_load and ex_store set: fault.
  - Neither set: ignored, stay IDLE, no completion.
  - Illegal funct3 (loads 011/110/111; stores ≥011): fault.
  - Misaligned (H: addr[0]≠0; W: addr[1:0]≠0): fault.
  - Fault path: no bus activity; stay IDLE; wb_valid = wb_fault = 1 at T+1; wb_we = 0.
- Legal accept: go to REQ; bus outputs are valid from T+1.
- REQ:
  - mem_req = 1; all mem_* are held stable until mem_gnt.
  - Store + gnt: mem_req drops, go to IDLE, wb_valid = 1 (wb_we = 0) next cycle.
  - Load + gnt without rvalid: go to RESP.
  - Load + gnt with rvalid in the same cycle: complete directly.
- RESP: mem_req = 0; wait for mem_rvalid; on rvalid, go to IDLE with wb_valid = wb_we = 1 next cycle.
- Minimum latency: load T+2 (gnt and rvalid in the cycle at T+1); store T+2.
- Byte enables:
  - SB: 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: 0011 << (2·addr[1]); mem_wdata = {2{wdata[15:0]}}.
  - SW: 1111; mem_wdata = wdata.
  - Loads: mem_be = 1111, mem_we = 0.
- Load extract: rdata >> (8·addr[1:0]), then:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Timeout:
  - Counter clears on accept and increments each cycle in REQ or RESP.
  - Reaching TIMEOUT_CYCLES forces IDLE with wb_valid = wb_fault = 1 and wb_we = 0.
  - mem_rvalid/mem_gnt seen in IDLE are ignored.
- Completion outputs:
  - wb_* are registered; wb_valid lasts exactly one cycle.
  - wb_rd/wb_data hold their last value otherwise.
  - A new accept is allowed in the same cycle wb_valid is high.

Test Plan:
- Reset: rst_n low 2 cycles mid-REQ -> mem_req = 0, ex_ready = 1, no wb_valid afterwards.
- LB addr 0x1003, gnt+rvalid immediate, rdata 0x80FF_FF00 -> wb_data 0xFFFF_FF80, wb_we = 1, wb_valid at T+2.
- LHU addr 0x2002, gnt delayed 3 cycles with mem_* stable, rvalid 2 cycles later, rdata 0xBEEF_1234 -> wb_data 0x0000_BEEF.
- SH addr 0x3002 wdata 0x0000_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_we = 1, wb_valid with wb_we = 0.
- LW addr 0x4001 -> no mem_req; wb_fault = 1 at T+1. Same result for ex_load = ex_store = 1 and for funct3 = 011 load.
- LW with gnt but no rvalid, TIMEOUT_CYCLES = 8 -> wb_fault at the 8th counted cycle; a late rvalid is ignored; next request is accepted normally.
